// File: rtl/vga_scanout_reader_if.sv
// vga_scanout_reader_if: frame-buffer read port and VGA pin bundle
interface vga_scanout_reader_if;
  logic [14:0] fbAddress;
  logic [2:0]  fbData;
  logic [7:0]  vgaR;
  logic [7:0]  vgaG;
  logic [7:0]  vgaB;
  logic        vgaHS;
  logic        vgaVS;
  logic        vgaBlankN;
  logic        vgaSyncN;
  logic        vgaClk;
  logic        frameStart;
  modport master (
    output fbAddress, vgaR, vgaG, vgaB, vgaHS, vgaVS, vgaBlankN, vgaSyncN, vgaClk, frameStart,
    input  fbData
  );
  modport slave (
    input  fbAddress, vgaR, vgaG, vgaB, vgaHS, vgaVS, vgaBlankN, vgaSyncN, vgaClk, frameStart,
    output fbData
  );
endinterface

// File: rtl/vga_scanout_reader.sv
// vga_scanout_reader: VGA timing, 4x upscaled frame-buffer fetch and pin driver
module vga_scanout_reader #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SCALE_SHIFT = 2,
  parameter int FB_WIDTH    = 160
) (
  input  logic clk,
  input  logic reset,
  vga_scanout_reader_if.master bus
);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] H_SS   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SE   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] V_SS   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SE   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  // Row length is split into two powers of two (160 = 128 + 32) so y*FB_WIDTH is two shifts and an add.
  localparam int ROW_HI = $clog2(FB_WIDTH) - 1;
  localparam int ROW_LO = $clog2(FB_WIDTH - (1 << ROW_HI));
  logic        pix_q;
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [9:0]  h_dly_q, v_dly_q;
  logic        vis_dly_q;
  logic        visible;
  logic [9:0]  fx, fy;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  r_q, g_q, b_q;
  logic        hs_q, vs_q, blank_q;
  // Counter advance on pixel ticks and frame-buffer address for the current position.
  always_comb begin
    visible = (h_q < H_VIS) && (v_q < V_VIS);
    h_d     = !pix_q ? h_q : (h_q == H_LAST ? '0 : h_q + 10'd1);
    v_d     = !(pix_q && h_q == H_LAST) ? v_q : (v_q == V_LAST ? '0 : v_q + 10'd1);
    fx      = h_q >> SCALE_SHIFT;
    fy      = v_q >> SCALE_SHIFT;
    addr_d  = visible ? ({5'b0, fy} << ROW_HI) + ({5'b0, fy} << ROW_LO) + {5'b0, fx} : '0;
  end
  // Tick phase, counters, address register and the one-pixel-delayed output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_q     <= 1'b0;
      h_q       <= '0;
      v_q       <= '0;
      addr_q    <= '0;
      h_dly_q   <= '0;
      v_dly_q   <= '0;
      vis_dly_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_q   <= 1'b0;
    end else begin
      pix_q <= ~pix_q;
      h_q   <= h_d;
      v_q   <= v_d;
      if (pix_q) begin
        addr_q    <= addr_d;
        h_dly_q   <= h_q;
        v_dly_q   <= v_q;
        vis_dly_q <= visible;
        r_q       <= {8{vis_dly_q & bus.fbData[2]}};
        g_q       <= {8{vis_dly_q & bus.fbData[1]}};
        b_q       <= {8{vis_dly_q & bus.fbData[0]}};
        hs_q      <= ~(h_dly_q >= H_SS && h_dly_q < H_SE);
        vs_q      <= ~(v_dly_q >= V_SS && v_dly_q < V_SE);
        blank_q   <= vis_dly_q;
      end
    end
  end
  assign bus.fbAddress  = addr_q;
  assign bus.vgaR       = r_q;
  assign bus.vgaG       = g_q;
  assign bus.vgaB       = b_q;
  assign bus.vgaHS      = hs_q;
  assign bus.vgaVS      = vs_q;
  assign bus.vgaBlankN  = blank_q;
  assign bus.vgaSyncN   = 1'b0;
  assign bus.vgaClk     = pix_q;
  assign bus.frameStart = pix_q && h_q == '0 && v_q == '0;
endmodule

// File: tb/tb_vga_scanout_reader.sv
// tb_vga_scanout_reader: directed checks of timing, addressing, colour and a full-frame scoreboard
module tb_vga_scanout_reader;
  localparam int HT = 80;
  localparam int VT = 22;
  localparam int FRAME = HT * VT;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int errors = 0;
  int n = 0;
  vga_scanout_reader_if bus ();
  vga_scanout_reader #(
    .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_VISIBLE(16), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .SCALE_SHIFT(2), .FB_WIDTH(160)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [2:0] pat(input logic [14:0] a);
    return a[2:0] ^ a[5:3] ^ a[8:6] ^ a[11:9] ^ a[14:12];
  endfunction
  always @(posedge clk) bus.fbData <= pat(bus.fbAddress);
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
    n += k;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
  endtask
  task automatic test_reset();
    logic [55:0] got;
    logic [55:0] exp;
    step(3);
    exp = {15'd0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0};
    got = {bus.fbAddress, bus.vgaR, bus.vgaG, bus.vgaB, bus.vgaHS, bus.vgaVS, bus.vgaBlankN,
           bus.vgaClk, bus.frameStart, bus.vgaSyncN, 11'd0};
    vectors++;
    if (got !== exp) begin errors++; $display("FAIL reset_initial: got %h expected %h", got, exp); end
    do_reset();
    step(2 * (5 * HT + 30) + 1 - n);
    vectors++;
    if (bus.vgaBlankN !== 1'b1) begin errors++; $display("FAIL pre_reset_blank: got %b expected 1", bus.vgaBlankN); end
    #2 reset = 1'b1;
    #1;
    got = {bus.fbAddress, bus.vgaR, bus.vgaG, bus.vgaB, bus.vgaHS, bus.vgaVS, bus.vgaBlankN,
           bus.vgaClk, bus.frameStart, bus.vgaSyncN, 11'd0};
    vectors++;
    if (got !== exp) begin errors++; $display("FAIL reset_midframe: got %h expected %h", got, exp); end
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    step(1);
    vectors++;
    if (bus.frameStart !== 1'b1) begin errors++; $display("FAIL reset_first_pulse: got %b expected 1", bus.frameStart); end
    step(1);
    vectors++;
    if (bus.frameStart !== 1'b0) begin errors++; $display("FAIL reset_pulse_width: got %b expected 0", bus.frameStart); end
  endtask
  task automatic test_frame_start();
    int pulses;
    do_reset();
    step(1);
    vectors++;
    if (bus.frameStart !== 1'b1 || bus.vgaClk !== 1'b1) begin
      errors++; $display("FAIL fs_first: got fs=%b clk=%b expected fs=1 clk=1", bus.frameStart, bus.vgaClk);
    end
    pulses = 0;
    do begin
      step(1);
      if (bus.frameStart === 1'b1) pulses++;
    end while (pulses == 0 && n < 2 * FRAME + 500);
    vectors++;
    if (n !== 2 * FRAME + 1) begin errors++; $display("FAIL fs_period: got edge %0d expected %0d", n, 2 * FRAME + 1); end
  endtask
  task automatic test_address();
    int tab [7][3] = '{'{0, 0, 0}, '{70, 0, 0}, '{7, 3, 1}, '{4, 4, 161},
                       '{8, 12, 482}, '{63, 15, 495}, '{10, 17, 0}};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(2 * (tab[i][1] * HT + tab[i][0]) + 2 - n);
      vectors++;
      if (bus.fbAddress !== 15'(tab[i][2])) begin
        errors++; $display("FAIL addr_h%0d_v%0d: got %0d expected %0d", tab[i][0], tab[i][1], bus.fbAddress, tab[i][2]);
      end
    end
  endtask
  task automatic test_hv_timing();
    int hs_low, hs_first, blank_hi, vs_low, vs_first, leak;
    do_reset();
    step(4);
    vs_low = 0; vs_first = -1; leak = 0;
    for (int v = 0; v < VT; v++) begin
      hs_low = 0; hs_first = -1; blank_hi = 0;
      for (int h = 0; h < HT; h++) begin
        if (bus.vgaHS === 1'b0) begin if (hs_first < 0) hs_first = h; hs_low++; end
        if (bus.vgaVS === 1'b0) begin if (vs_first < 0) vs_first = v * HT + h; vs_low++; end
        if (bus.vgaBlankN === 1'b1) blank_hi++;
        if (bus.vgaBlankN !== 1'b1 && {bus.vgaR, bus.vgaG, bus.vgaB} !== 24'd0) leak++;
        step(2);
      end
      vectors++;
      if (hs_low !== 8 || hs_first !== 68) begin
        errors++; $display("FAIL hsync_line%0d: got %0d low from %0d expected 8 low from 68", v, hs_low, hs_first);
      end
      vectors++;
      if (blank_hi !== (v < 16 ? 64 : 0)) begin
        errors++; $display("FAIL blank_line%0d: got %0d expected %0d", v, blank_hi, v < 16 ? 64 : 0);
      end
    end
    vectors++;
    if (vs_low !== 2 * HT || vs_first !== 18 * HT) begin
      errors++; $display("FAIL vsync: got %0d low from %0d expected %0d low from %0d", vs_low, vs_first, 2 * HT, 18 * HT);
    end
    vectors++;
    if (leak !== 0) begin errors++; $display("FAIL blank_colour: got %0d nonzero expected 0", leak); end
  endtask
  task automatic test_colour();
    int pos;
    do_reset();
    step(2 * 8 + 4 - n);
    vectors++;
    if ({bus.vgaR, bus.vgaG, bus.vgaB} !== 24'h00FF00) begin
      errors++; $display("FAIL colour_010: got %h expected 00ff00", {bus.vgaR, bus.vgaG, bus.vgaB});
    end
    step(2 * 20 + 4 - n);
    vectors++;
    if ({bus.vgaR, bus.vgaG, bus.vgaB} !== 24'hFF00FF) begin
      errors++; $display("FAIL colour_101: got %h expected ff00ff", {bus.vgaR, bus.vgaG, bus.vgaB});
    end
    for (int h = 8; h < 12; h++) begin
      step(2 * (4 * HT + h) + 2 - n);
      vectors++;
      if (bus.fbAddress !== 15'd162) begin errors++; $display("FAIL upscale_h%0d: got %0d expected 162", h, bus.fbAddress); end
    end
    for (int v = 5; v < 8; v++) begin
      step(2 * (v * HT + 8) + 2 - n);
      vectors++;
      if (bus.fbAddress !== 15'd162) begin errors++; $display("FAIL upscale_v%0d: got %0d expected 162", v, bus.fbAddress); end
    end
    pos = 16 * HT + 5;
    step(2 * pos + 4 - n);
    vectors++;
    if ({bus.vgaBlankN, bus.vgaR, bus.vgaG, bus.vgaB} !== 25'd0) begin
      errors++; $display("FAIL colour_vblank: got %h expected 0", {bus.vgaBlankN, bus.vgaR, bus.vgaG, bus.vgaB});
    end
  endtask
  task automatic test_scoreboard();
    logic [2:0] img [4][16];
    bit seen [4][16];
    logic [2:0] col;
    int bad;
    do_reset();
    step(4);
    bad = 0;
    for (int y = 0; y < 4; y++) for (int x = 0; x < 16; x++) seen[y][x] = 1'b0;
    for (int p = 0; p < FRAME; p++) begin
      if (bus.vgaBlankN === 1'b1) begin
        col = {bus.vgaR[0], bus.vgaG[0], bus.vgaB[0]};
        if (bus.vgaR !== {8{col[2]}} || bus.vgaG !== {8{col[1]}} || bus.vgaB !== {8{col[0]}}) bad++;
        if (!seen[(p / HT) >> 2][(p % HT) >> 2]) begin
          seen[(p / HT) >> 2][(p % HT) >> 2] = 1'b1;
          img[(p / HT) >> 2][(p % HT) >> 2] = col;
        end else if (img[(p / HT) >> 2][(p % HT) >> 2] !== col) bad++;
      end
      step(2);
    end
    vectors++;
    if (bad !== 0) begin errors++; $display("FAIL sb_consistency: got %0d bad samples expected 0", bad); end
    for (int y = 0; y < 4; y++) for (int x = 0; x < 16; x++) begin
      vectors++;
      if (!seen[y][x] || img[y][x] !== pat(15'(y * 160 + x))) begin
        errors++; $display("FAIL sb_pixel_%0d_%0d: got %b seen=%0d expected %b", x, y, img[y][x], seen[y][x], pat(15'(y * 160 + x)));
      end
    end
  endtask
  initial begin
    test_reset();
    test_frame_start();
    test_address();
    test_hv_timing();
    test_colour();
    test_scoreboard();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
